// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Duty-cycle sequencer feeding the PWM counter's (N+1)-bit duty input.
//   After a start it moves duty from its present value to a programmed target
//   in fixed steps. Updates land only on PWM period boundaries (period_tick),
//   so the PWM output never sees a duty change in the middle of a period.
//   Typical uses are motor soft-start/soft-stop and LED fades.
//
//   Optional feature: define PWM_RAMP_LOOP_EN to add the 'loop' input. With
//   loop=1 the ramp bounces between the start duty and the target
//   indefinitely (triangle/breathing) until abort. Without the macro only the
//   single-shot ramp exists and there is no loop port.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   start        one-cycle ramp request, accepted only in IDLE
//   abort        return to IDLE holding duty; beats start and period_tick
//   loop         (PWM_RAMP_LOOP_EN only) bounce between endpoints forever
//   target       destination duty, clamped to 2^N, sampled on start
//   step         duty change per update (0 means 1), sampled on start
//   interval     one update per interval+1 period ticks, sampled on start
//   period_tick  end-of-period pulse from the PWM block
//   duty         registered duty to the PWM block
//   duty_load    one-cycle pulse in every cycle a new duty value appears
//   busy         state == RAMP
//   done         state == DONE (one-cycle pulse)

module pwm_ramp_ctrl #(
  parameter int N          = 4,
  parameter int INTERVAL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
`ifdef PWM_RAMP_LOOP_EN
  input  logic                  loop,
`endif
  input  logic [N:0]            target,
  input  logic [N:0]            step,
  input  logic [INTERVAL_W-1:0] interval,
  input  logic                  period_tick,
  output logic [N:0]            duty,
  output logic                  duty_load,
  output logic                  busy,
  output logic                  done
);

  // state | meaning
  // IDLE  | waiting for start; duty holds
  // RAMP  | stepping duty toward tgt_q on every (int_q+1)-th period tick
  // DONE  | target reached; one-cycle done pulse, then IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N:0] FULL_ON  = {1'b1, {N{1'b0}}};
  localparam logic [N:0] STEP_ONE = {{N{1'b0}}, 1'b1};

  state_t                state, state_n;
  logic [N:0]            duty_n;
  logic                  load_n;
  logic [INTERVAL_W-1:0] cnt, cnt_n;
  logic [N:0]            tgt_q, tgt_n;
  logic [N:0]            step_q, step_n;
  logic [INTERVAL_W-1:0] int_q, int_n;
`ifdef PWM_RAMP_LOOP_EN
  logic                  loop_q, loop_n;
  logic [N:0]            orig_q, orig_n;
`endif

  logic [N:0]   tgt_clamp;
  logic [N+1:0] sum_w;
  logic [N+1:0] diff_w;
  logic [N+1:0] tgt_w;
  logic [N:0]   ramp_next;

  // Next ramp value. One extra bit of headroom lets the sum/difference be
  // compared against the target before truncation, so a large step lands
  // exactly on the target instead of wrapping or overshooting.
  always_comb begin
    tgt_clamp = (target > FULL_ON) ? FULL_ON : target;
    tgt_w     = {1'b0, tgt_q};
    sum_w     = {1'b0, duty} + {1'b0, step_q};
    diff_w    = {1'b0, duty} - {1'b0, step_q};
    if (tgt_q > duty) begin
      ramp_next = (sum_w > tgt_w) ? tgt_q : sum_w[N:0];
    end else begin
      // diff_w MSB set means duty - step went negative
      ramp_next = (diff_w[N+1] || (diff_w < tgt_w)) ? tgt_q : diff_w[N:0];
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty;
    load_n  = 1'b0;
    cnt_n   = cnt;
    tgt_n   = tgt_q;
    step_n  = step_q;
    int_n   = int_q;
`ifdef PWM_RAMP_LOOP_EN
    loop_n  = loop_q;
    orig_n  = orig_q;
`endif
    case (state)
      IDLE: begin
        if (start && !abort) begin
          tgt_n   = tgt_clamp;
          step_n  = (step == '0) ? STEP_ONE : step;
          int_n   = interval;
          cnt_n   = '0;
`ifdef PWM_RAMP_LOOP_EN
          loop_n  = loop;
          orig_n  = duty;
`endif
          state_n = (tgt_clamp == duty) ? DONE : RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (period_tick) begin
          if (cnt != int_q) begin
            cnt_n = cnt + INTERVAL_W'(1);
          end else begin
            cnt_n  = '0;
            duty_n = ramp_next;
            load_n = 1'b1;
            if (ramp_next == tgt_q) begin
`ifdef PWM_RAMP_LOOP_EN
              // Looping: swap endpoints and head back the other way.
              if (loop_q) begin
                tgt_n  = orig_q;
                orig_n = tgt_q;
              end else begin
                state_n = DONE;
              end
`else
              state_n = DONE;
`endif
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty      <= '0;
      duty_load <= 1'b0;
      cnt       <= '0;
      tgt_q     <= '0;
      step_q    <= STEP_ONE;
      int_q     <= '0;
`ifdef PWM_RAMP_LOOP_EN
      loop_q    <= 1'b0;
      orig_q    <= '0;
`endif
    end else begin
      duty      <= duty_n;
      duty_load <= load_n;
      cnt       <= cnt_n;
      tgt_q     <= tgt_n;
      step_q    <= step_n;
      int_q     <= int_n;
`ifdef PWM_RAMP_LOOP_EN
      loop_q    <= loop_n;
      orig_q    <= orig_n;
`endif
    end
  end

  assign busy = (state == RAMP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl. The driver issues ramps and, from a plain
// arithmetic model of the ramp rules, queues every expected duty_load/done
// event tagged with the cycle it must appear in. An independent monitor pops
// and compares whenever the DUT shows duty_load or done.
// Define PWM_RAMP_LOOP_EN to include the loop port and its tests.

module tb_pwm_ramp_ctrl;
  localparam int N  = 4;
  localparam int IW = 4;
  localparam int FULL = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          period_tick = 1'b0;
  logic [N:0]    target = '0;
  logic [N:0]    step = '0;
  logic [IW-1:0] interval = '0;
  logic [N:0]    duty;
  logic          duty_load;
  logic          busy;
  logic          done;
`ifdef PWM_RAMP_LOOP_EN
  logic          loop = 1'b0;
`endif

  pwm_ramp_ctrl #(.N(N), .INTERVAL_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
`ifdef PWM_RAMP_LOOP_EN
    .loop        (loop),
`endif
    .target      (target),
    .step        (step),
    .interval    (interval),
    .period_tick (period_tick),
    .duty        (duty),
    .duty_load   (duty_load),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int duty;
    bit load;
    bit done;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  model_duty = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int d, input bit ld, input bit dn);
    ev_t e;
    e.cyc = c; e.duty = d; e.load = ld; e.done = dn;
    sbq.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    ev_t e;
    logic [N:0] prev;
    prev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b1) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          e = sbq.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_event: nothing seen, expected duty=%0d load=%0b done=%0b at cycle %0d",
                   e.duty, e.load, e.done, e.cyc);
        end
        if (duty_load === 1'b1 || done === 1'b1) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got duty=%0d load=%0b done=%0b at cycle %0d, expected none",
                     duty, duty_load, done, cyc);
          end else begin
            e = sbq.pop_front();
            if (e.cyc != cyc || e.load != duty_load || e.done != done ||
                (e.load && e.duty != 32'(duty))) begin
              errors++;
              $display("FAIL event: got cyc=%0d duty=%0d load=%0b done=%0b expected cyc=%0d duty=%0d load=%0b done=%0b",
                       cyc, duty, duty_load, done, e.cyc, e.duty, e.load, e.done);
            end
          end
        end
        if (duty_load !== 1'b1 && duty !== prev) begin
          checks++;
          errors++;
          $display("FAIL duty_no_load: got duty=%0d expected %0d (no duty_load) cycle %0d", duty, prev, cyc);
        end
      end
      prev = duty;
    end
  end

  task automatic scramble_cfg();
    target   = 5'($urandom_range(0, 31));
    step     = 5'($urandom_range(0, 31));
    interval = 4'($urandom_range(0, 15));
`ifdef PWM_RAMP_LOOP_EN
    loop     = 1'($urandom_range(0, 1));
`endif
  endtask

  // One ramp: start, then ticks every 'gap' cycles. abort_after >= 0 raises
  // abort together with the tick that follows that many updates.
  task automatic run_ramp(input int tgt_in, input int step_in, input int int_in,
                          input int gap, input int abort_after, input bit lp);
    int tgt, stp, orig, cur, updates, ticks, tmp;
    bit at_end, finished;
    tgt = (tgt_in > FULL) ? FULL : tgt_in;
    stp = (step_in == 0) ? 1 : step_in;
    cur = model_duty;
    orig = cur;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; period_tick = 1'b0;
    target = 5'(tgt_in); step = 5'(step_in); interval = 4'(int_in);
`ifdef PWM_RAMP_LOOP_EN
    loop = lp;
`endif
    if (tgt == cur) begin
      push_ev(cyc + 1, cur, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      scramble_cfg();
      chk("busy_after_equal_start", 32'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 0);
      return;
    end
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    chk("busy_after_start", 32'(busy), 1);
    updates = 0; ticks = 0; finished = 1'b0;
    while (!finished) begin
      if (ticks > 400) begin
        checks++; errors++;
        $display("FAIL ramp_timeout: got %0d ticks expected at most 400", ticks);
        break;
      end
      start = 1'b0;
      period_tick = 1'b1;
      if (abort_after >= 0 && updates == abort_after) begin
        abort = 1'b1;
        @(negedge clk);
        period_tick = 1'b0; abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_duty_hold", 32'(duty), cur);
        chk("abort_no_load", 32'(duty_load), 0);
        @(negedge clk);
        chk("abort_no_done", 32'(done), 0);
        model_duty = cur;
        return;
      end
      if ((ticks % (int_in + 1)) == int_in) begin
        if (tgt > cur) cur = (cur + stp > tgt) ? tgt : cur + stp;
        else           cur = (cur - stp < tgt) ? tgt : cur - stp;
        updates++;
        at_end = (cur == tgt);
        push_ev(cyc + 1, cur, 1'b1, at_end && !lp);
        if (at_end && lp) begin
          tmp = tgt; tgt = orig; orig = tmp;
        end
        finished = at_end && !lp;
      end
      ticks++;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        period_tick = 1'b0;
        start = !finished && ($urandom_range(0, 1) == 1);
        scramble_cfg();
        if (!finished && g == 0) chk("busy_in_ramp", 32'(busy), 1);
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_after_done", 32'(done), 0);
    model_duty = cur;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      period_tick = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    period_tick = 1'b0; abort = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_duty"}, 32'(duty), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_load"}, 32'(duty_load), 0);
  endtask

  initial begin : driver
    int t, s, iv, gp, ab;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reset_checks("reset_init");
    model_duty = 0;

    run_ramp(10, 3, 0, 16, -1, 1'b0);   // 3 6 9 10
    run_ramp(4, 2, 2, 5, -1, 1'b0);     // 8 6 4, every 3rd tick
    run_ramp(12, 2, 0, 3, 1, 1'b0);     // 6, then abort with tick
    run_ramp(20, 5, 1, 2, -1, 1'b0);    // clamp: 11 16
    run_ramp(13, 0, 0, 2, -1, 1'b0);    // step 0: 15 14 13
    run_ramp(13, 4, 0, 2, -1, 1'b0);    // target == duty
    idle_cycles(4);

    for (int k = 0; k < 30; k++) begin
      t  = $urandom_range(0, 31);
      s  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      iv = $urandom_range(0, 3);
      gp = $urandom_range(1, 5);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
      run_ramp(t, s, iv, gp, ab, 1'b0);
      idle_cycles($urandom_range(0, 3));
    end

    // Reset held two cycles in the middle of a ramp.
    if (model_duty == FULL) run_ramp(0, 8, 0, 1, -1, 1'b0);
    @(negedge clk);
    start = 1'b1; target = 5'(FULL); step = 5'd1; interval = 4'd0;
`ifdef PWM_RAMP_LOOP_EN
    loop = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0; period_tick = 1'b1;
    push_ev(cyc + 1, model_duty + 1, 1'b1, (model_duty + 1) == FULL);
    @(negedge clk);
    period_tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    model_duty = 0;
    reset_checks("reset_mid_ramp");
    run_ramp(5, 2, 1, 2, -1, 1'b0);

`ifdef PWM_RAMP_LOOP_EN
    run_ramp(2, 3, 0, 2, -1, 1'b0);
    run_ramp(8, 3, 0, 4, 6, 1'b1);      // 5 8 5 2 5 8, abort
    for (int k = 0; k < 6; k++) begin
      run_ramp($urandom_range(0, 31), $urandom_range(0, 6), $urandom_range(0, 2),
               $urandom_range(1, 4), $urandom_range(2, 12), 1'b1);
      idle_cycles(2);
    end
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Duty-cycle sequencer for the PWM counter block (timer-prescaled counter with an (N+1)-bit duty input).
- Ramps duty from its current value to a programmed target in fixed steps.
- Updates only on PWM period boundaries, so no mid-period glitch reaches the PWM output.
- Used for soft-start/soft-stop of motors and LED fades. Sits between the register interface and the PWM duty input.

Parameters:
- N, 4, PWM counter width. Duty is N+1 bits; 2^N means full on.
- INTERVAL_W, 4, width of the step-interval field.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  one-cycle request to begin a ramp. Sampled only in IDLE.
- abort  in  1  stop the ramp and return to IDLE. Highest priority after reset.
- target  in  N+1  destination duty. Sampled on the accepted start.
- step  in  N+1  duty increment/decrement per update. Sampled on start.
- interval  in  INTERVAL_W  one update is applied every interval+1 period ticks.
- period_tick  in  1  one-cycle pulse from the PWM block at end of each PWM period.
- duty  out  N+1  registered duty to the PWM block.
- duty_load  out  1  one-cycle pulse coincident with every duty change.
- busy  out  1  high while state == RAMP.
- done  out  1  one-cycle pulse; high while state == DONE.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, duty=0, duty_load=0, interval counter=0. busy=0 and done=0 (both decoded from state).
- States: IDLE, RAMP, DONE.
- IDLE:
  - start=1 latches tgt_q, step_q, int_q.
  - tgt_q = min(target, 2^N).
  - step_q = 1 if step==0, else step.
  - Clears interval counter.
  - Next state is RAMP; if tgt_q == duty, next state is DONE instead.
  - busy (or done) rises the cycle after start is sampled.
- RAMP, each cycle with period_tick=1:
  - If counter != int_q: counter increments.
  - Else: counter clears, and duty moves toward tgt_q by step_q.
  - Up: duty <= min(duty+step_q, tgt_q). Down: duty <= max(duty-step_q, tgt_q).
  - Arithmetic in N+2 bits; no overshoot, no wrap-around.
  - duty_load=1 in the same cycle the new duty value appears.
  - When the new duty equals tgt_q, state goes to DONE on that same edge.
  - Net timing: duty/duty_load appear one cycle after the final tick; done is high in the same cycle as the last duty_load.
- DONE: one cycle only. done=1, busy=0, then IDLE.
- abort=1 in RAMP or DONE:
  - Next state is IDLE and duty holds its current value.
  - No done pulse and no duty_load.
  - abort overrides a coincident period_tick.
- start while not in IDLE is ignored. target/step/interval changes during RAMP are ignored (latched copies are used).
- period_tick in IDLE or DONE has no effect.
- duty never changes except on a duty_load cycle or on reset.

Optional Feature:
- Macro: PWM_RAMP_LOOP_EN.
- Defined:
  - Adds input port loop (1 bit), sampled with start.
  - If loop=1, reaching tgt_q does not enter DONE. Instead the endpoints swap: the new target is the duty value at start time, and the ramp continues in the reverse direction indefinitely (triangle/breathing).
  - busy stays 1, no done pulses occur, and only abort exits.
  - loop=0 behaves as in the non-loop case.
- Undefined: no loop port. Single-shot ramp only, as specified above.

Test Plan:
- Reset: hold reset 2 cycles mid-ramp -> next cycle duty=0, busy=0, done=0, duty_load=0.
- Ramp up: duty=0, start with target=10, step=3, interval=0, period_tick every 16 cycles -> duty 3, 6, 9, 10 on four duty_load pulses, one per tick. done=1 in the same cycle as the 4th duty_load; busy low next cycle.
- Ramp down with interval: duty=10, start with target=4, step=2, interval=2 -> updates on every 3rd tick: 8, 6, 4; no update on the other ticks; done after the 4.
- Abort and ignored start: abort asserted in the same cycle as a tick after duty reaches 6 -> duty stays 6, no done, busy=0 next cycle. A start pulse during RAMP causes no change to tgt_q.
- Edges:
  - target=20 -> clamped; duty ends at 16.
  - step=0 -> ramps by 1.
  - start with target==duty -> done pulse the next cycle, no duty_load.
- Loop (PWM_RAMP_LOOP_EN): duty=2, target=8, step=3, loop=1 -> duty 5, 8, 5, 2, 5, ... with no done. abort stops the sequence and holds duty.
